// File: rtl/wam_round_scheduler_pkg.sv
// wam_round_scheduler_pkg: FSM state encoding, mode codes, round limits and the per-level gap/on unit table
package wam_round_scheduler_pkg;
  typedef enum logic [2:0] {S_IDLE, S_GAP, S_LIT, S_SCORE, S_DONE} state_t;
  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_TIMED = 2'b01;
  localparam logic [1:0] MODE_DEATH = 2'b10;
  localparam logic [1:0] MODE_CONT = 2'b11;
  localparam logic [6:0] MAX_ROUNDS = 7'd25;
  localparam logic [6:0] MAX_ROUNDS_EXT = 7'd50;
  localparam logic [3:0] NO_POS = 4'hf;
  function automatic logic [1:0] level_of(input logic [3:0] d);
    return d == 4'b0001 ? 2'd0 : d == 4'b0010 ? 2'd1 : d == 4'b0100 ? 2'd2 : d == 4'b1000 ? 2'd3 : 2'd1;
  endfunction
  function automatic logic [7:0] gap_units(input logic [1:0] l);
    return l == 2'd0 ? 8'd8 : l == 2'd1 ? 8'd4 : l == 2'd2 ? 8'd2 : 8'd1;
  endfunction
  function automatic logic [7:0] on_units(input logic [1:0] l);
    return l == 2'd0 ? 8'd8 : l == 2'd3 ? 8'd2 : 8'd4;
  endfunction
endpackage

// File: rtl/wam_round_timer.sv
// wam_round_timer: loadable down-counter of T_UNIT-cycle units; clk/reset/load/clear/units in, done high in the last cycle of units*T_UNIT
module wam_round_timer #(
  parameter int T_UNIT = 12_500_000,
  parameter int UW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          clear,
  input  logic [UW-1:0] units,
  output logic          done
);
  localparam int PW = T_UNIT > 1 ? $clog2(T_UNIT) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(T_UNIT - 1);
  logic [PW-1:0] pre;
  logic [UW-1:0] cnt;
  logic run;
  assign done = run && cnt == UW'(1) && pre == '0;
  always_ff @(posedge clk)
    if (reset) begin
      run <= 1'b0;
      cnt <= '0;
      pre <= '0;
    end else if (load) begin
      run <= units != '0;
      cnt <= units;
      pre <= PRE_MAX;
    end else if (clear) begin
      run <= 1'b0;
    end else if (run) begin
      pre <= pre == '0 ? PRE_MAX : pre - PW'(1);
      if (pre == '0) cnt <= cnt - UW'(1);
      if (done) run <= 1'b0;
    end
endmodule

// File: rtl/wam_round_scheduler.sv
// wam_round_scheduler: whack-a-mole game sequencer; start/difficulty/mode/extended/rnd_pos/key_valid/key_code in, lights/hits/rounds/lives_left/time_left/level/hit_pulse/miss_pulse/game_over out
module wam_round_scheduler
  import wam_round_scheduler_pkg::*;
#(
  parameter int T_UNIT = 12_500_000,
  parameter int SEC_UNITS = 4,
  parameter int GAME_SECS = 60,
  parameter int LIVES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] difficulty,
  input  logic [1:0] mode,
  input  logic       extended,
  input  logic [3:0] rnd_pos,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [8:0] lights,
  output logic [5:0] hits,
  output logic [6:0] rounds,
  output logic [1:0] lives_left,
  output logic [5:0] time_left,
  output logic [1:0] level,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       game_over
);
  state_t state, nxt;
  logic [1:0] mode_r, start_lvl;
  logic ext_r, was_hit, go, in_game, hit, time_end, fin, rt_load, rt_done, st_done;
  logic [3:0] pos, pos_raw, pos_new;
  logic [5:0] hits_inc;
  logic [7:0] rt_units;
  assign go = start && (state == S_IDLE || state == S_DONE);
  assign in_game = state == S_GAP || state == S_LIT || state == S_SCORE;
  assign start_lvl = mode == MODE_CONT ? 2'd0 : level_of(difficulty);
  assign hit = state == S_LIT && key_valid && key_code == pos;
  assign time_end = mode_r == MODE_TIMED && (time_left == 6'd0 || (st_done && time_left == 6'd1));
  assign fin = time_end || rounds == (ext_r ? MAX_ROUNDS_EXT : MAX_ROUNDS) || (mode_r == MODE_DEATH && lives_left == 2'd0);
  assign pos_raw = rnd_pos >= 4'd9 ? rnd_pos - 4'd9 : rnd_pos;
  // never light the same mole twice in a row
  assign pos_new = pos_raw != pos ? pos_raw : pos_raw == 4'd8 ? 4'd0 : pos_raw + 4'd1;
  assign hits_inc = hits + 6'd1;
  assign lights = state == S_LIT ? 9'd1 << pos : 9'd0;
  assign hit_pulse = state == S_SCORE && was_hit;
  assign miss_pulse = state == S_SCORE && !was_hit;
  assign game_over = state == S_DONE;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE: nxt = start ? S_GAP : state;
      S_GAP: nxt = time_end ? S_DONE : rt_done ? S_LIT : S_GAP;
      S_LIT: nxt = time_end ? S_DONE : (hit || rt_done) ? S_SCORE : S_LIT;
      S_SCORE: nxt = fin ? S_DONE : S_GAP;
      default: nxt = S_IDLE;
    endcase
  end
  assign rt_load = (nxt == S_GAP && state != S_GAP) || (state == S_GAP && nxt == S_LIT);
  // a new game's first gap uses the level being latched this cycle
  assign rt_units = nxt == S_GAP ? gap_units(in_game ? level : start_lvl) : on_units(level);
  wam_round_timer #(.T_UNIT(T_UNIT), .UW(8)) u_round (
    .clk(clk), .reset(reset), .load(rt_load), .clear(!in_game), .units(rt_units), .done(rt_done)
  );
  wam_round_timer #(.T_UNIT(T_UNIT), .UW(8)) u_secs (
    .clk(clk), .reset(reset), .load(go || (in_game && st_done)), .clear(!in_game), .units(8'(SEC_UNITS)), .done(st_done)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      mode_r <= MODE_NORMAL;
      ext_r <= 1'b0;
      level <= 2'd1;
      pos <= NO_POS;
      was_hit <= 1'b0;
      hits <= '0;
      rounds <= '0;
      lives_left <= 2'(LIVES);
      time_left <= '0;
    end else begin
      state <= nxt;
      if (go) begin
        mode_r <= mode;
        ext_r <= extended;
        level <= start_lvl;
        pos <= NO_POS;
        hits <= '0;
        rounds <= '0;
        lives_left <= 2'(LIVES);
        time_left <= mode == MODE_TIMED ? 6'(GAME_SECS) : 6'd0;
      end else begin
        if (state == S_GAP && nxt == S_LIT) pos <= pos_new;
        if (nxt == S_SCORE) begin
          was_hit <= hit;
          rounds <= rounds + 7'd1;
          if (hit && hits != 6'd63) hits <= hits_inc;
          if (hit && hits != 6'd63 && mode_r == MODE_CONT && level != 2'd3 && hits_inc % 6'd5 == 6'd0) level <= level + 2'd1;
          if (!hit && mode_r == MODE_DEATH && lives_left != 2'd0) lives_left <= lives_left - 2'd1;
        end
        if (in_game && st_done && mode_r == MODE_TIMED && time_left != 6'd0) time_left <= time_left - 6'd1;
      end
    end
endmodule
